bsg_manycore_dram_burst_sequencer: RTL and testbench

//  Walks a word burst (base EVA, length) through a bsg_manycore_dram_hash_function instance.

---
 rtl/bsg_manycore_dram_burst_sequencer.sv | 154 +++++++++++++++
 tb/tb_bsg_manycore_dram_burst_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_dram_burst_sequencer.sv
// Walks a word burst through the manycore DRAM hash and issues one valid/yumi request per word.
// Optional counters: define BSG_MANYCORE_DRAM_SEQ_STATS_EN to enable stat_words_o/stat_stalls_o.
module bsg_manycore_dram_burst_sequencer #(
    parameter int data_width_p                 = 32,
    parameter int addr_width_p                 = 28,
    parameter int x_cord_width_p               = 7,
    parameter int y_cord_width_p               = 7,
    parameter int pod_x_cord_width_p           = 3,
    parameter int pod_y_cord_width_p           = 4,
    parameter int x_subcord_width_p            = 4,
    parameter int y_subcord_width_p            = 3,
    parameter int num_vcache_rows_p            = 1,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int len_width_p                  = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          cmd_v_i,
    output logic                          cmd_ready_o,
    input  logic [data_width_p-1:0]       cmd_eva_i,
    input  logic [len_width_p-1:0]        cmd_len_i,
    input  logic [pod_x_cord_width_p-1:0] pod_x_i,
    input  logic [pod_y_cord_width_p-1:0] pod_y_i,
    output logic                          out_v_o,
    input  logic                          out_yumi_i,
    output logic [x_cord_width_p-1:0]     out_x_cord_o,
    output logic [y_cord_width_p-1:0]     out_y_cord_o,
    output logic [addr_width_p-1:0]       out_epa_o,
    output logic                          out_line_first_o,
    output logic                          out_last_o,
    output logic                          done_o,
    output logic [31:0]                   stat_words_o,
    output logic [31:0]                   stat_stalls_o
);

    localparam int lg_block_lp      = $clog2(vcache_block_size_in_words_p);
    localparam int lg_rows_lp       = $clog2(num_vcache_rows_p);
    localparam int dram_index_w_lp  = 1 + x_subcord_width_p + lg_rows_lp;
    localparam int index_lsb_lp     = 2 + lg_block_lp;
    localparam int bank_shift_lp    = index_lsb_lp + dram_index_w_lp;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    state_e state_r, state_n;

    logic [data_width_p-1:0]       eva_r;
    logic [len_width_p-1:0]        rem_r;
    logic [pod_x_cord_width_p-1:0] pod_x_r;
    logic [pod_y_cord_width_p-1:0] pod_y_r;
    logic                          first_r;

    logic accept, fire;
    assign accept = (state_r == IDLE) & cmd_v_i;
    assign fire   = (state_r == RUN) & out_yumi_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            eva_r   <= '0;
            rem_r   <= '0;
            pod_x_r <= '0;
            pod_y_r <= '0;
            first_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                eva_r   <= {cmd_eva_i[data_width_p-1:2], 2'b00};
                rem_r   <= cmd_len_i;
                pod_x_r <= pod_x_i;
                pod_y_r <= pod_y_i;
                first_r <= 1'b1;
            end else if (fire) begin
                eva_r   <= eva_r + data_width_p'(4);
                rem_r   <= rem_r - len_width_p'(1);
                first_r <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n     = state_r;
        cmd_ready_o = 1'b0;
        out_v_o     = 1'b0;
        done_o      = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_v_i)
                    state_n = (cmd_len_i == '0) ? DONE : RUN;
            end
            RUN: begin
                out_v_o = 1'b1;
                if (out_yumi_i && rem_r == len_width_p'(1))
                    state_n = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Hash: the dram index above the line offset picks vcache column, row and
    // north/south side; the bits above it form the per-bank line index.
    logic [lg_block_lp-1:0]       block_offset;
    logic [x_subcord_width_p-1:0] x_subcord;
    logic [y_subcord_width_p-1:0] row_idx, y_subcord;
    logic [pod_y_cord_width_p-1:0] pod_y_adj;
    logic                          south;
    logic [data_width_p-1:0]       bank_index, epa_full;

    assign block_offset = eva_r[2 +: lg_block_lp];
    assign x_subcord    = eva_r[index_lsb_lp +: x_subcord_width_p];
    assign south        = eva_r[bank_shift_lp-1];

    if (lg_rows_lp > 0) begin : g_rows
        assign row_idx = y_subcord_width_p'(eva_r[index_lsb_lp+x_subcord_width_p +: lg_rows_lp]);
    end else begin : g_one_row
        assign row_idx = '0;
    end

    // North vcaches count down from the pod edge, south ones count up.
    assign y_subcord  = south ? row_idx : ~row_idx;
    assign pod_y_adj  = south ? pod_y_r + pod_y_cord_width_p'(1) : pod_y_r - pod_y_cord_width_p'(1);
    assign bank_index = eva_r >> bank_shift_lp;
    assign epa_full   = (bank_index << lg_block_lp) | data_width_p'(block_offset);

    assign out_x_cord_o     = {pod_x_r, x_subcord};
    assign out_y_cord_o     = {pod_y_adj, y_subcord};
    assign out_epa_o        = epa_full[addr_width_p-1:0];
    assign out_line_first_o = out_v_o & (first_r | (block_offset == '0));
    assign out_last_o       = out_v_o & (rem_r == len_width_p'(1));

`ifdef BSG_MANYCORE_DRAM_SEQ_STATS_EN
    logic [31:0] words_r, stalls_r;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            words_r  <= '0;
            stalls_r <= '0;
        end else begin
            if (fire && words_r != '1)
                words_r <= words_r + 32'd1;
            if (out_v_o && !out_yumi_i && stalls_r != '1)
                stalls_r <= stalls_r + 32'd1;
        end
    end
    assign stat_words_o  = words_r;
    assign stat_stalls_o = stalls_r;
`else
    assign stat_words_o  = '0;
    assign stat_stalls_o = '0;
`endif

endmodule

// File: tb/tb_bsg_manycore_dram_burst_sequencer.sv
// Randomized bench for the DRAM burst sequencer against an arithmetic hash/burst model.
module tb_bsg_manycore_dram_burst_sequencer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cmd_v_i, cmd_ready_o;
    logic [31:0] cmd_eva_i;
    logic [15:0] cmd_len_i;
    logic [2:0]  pod_x_i;
    logic [3:0]  pod_y_i;
    logic        out_v_o, out_yumi_i;
    logic [6:0]  out_x_cord_o, out_y_cord_o;
    logic [27:0] out_epa_o;
    logic        out_line_first_o, out_last_o, done_o;
    logic [31:0] stat_words_o, stat_stalls_o;

    always #5 clk = ~clk;

    bsg_manycore_dram_burst_sequencer dut (
        .clk_i(clk), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_eva_i(cmd_eva_i),
        .cmd_len_i(cmd_len_i), .pod_x_i(pod_x_i), .pod_y_i(pod_y_i),
        .out_v_o(out_v_o), .out_yumi_i(out_yumi_i),
        .out_x_cord_o(out_x_cord_o), .out_y_cord_o(out_y_cord_o), .out_epa_o(out_epa_o),
        .out_line_first_o(out_line_first_o), .out_last_o(out_last_o), .done_o(done_o),
        .stat_words_o(stat_words_o), .stat_stalls_o(stat_stalls_o)
    );

    int total = 0;
    int bad   = 0;
    longint unsigned m_words, m_stalls;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // 8-word lines, 32 vcaches (16 north, 16 south) interleaved by line.
    function automatic void hash_model(input logic [31:0] eva, input logic [2:0] px,
                                       input logic [3:0] py, output logic [6:0] x,
                                       output logic [6:0] y, output logic [27:0] epa);
        int unsigned word, blk, vc;
        logic [3:0] ny;
        word = eva >> 2;
        blk  = word / 8;
        vc   = blk % 32;
        x    = 7'(px * 16 + vc % 16);
        if (vc >= 16) begin
            ny = py + 4'd1;
            y  = {ny, 3'b000};
        end else begin
            ny = py - 4'd1;
            y  = {ny, 3'b111};
        end
        epa = 28'((blk / 32) * 8 + word % 8);
    endfunction

    task automatic chk_stats();
`ifdef BSG_MANYCORE_DRAM_SEQ_STATS_EN
        chk("stat_words", stat_words_o, m_words);
        chk("stat_stalls", stat_stalls_o, m_stalls);
`else
        chk("stat_words_off", stat_words_o, 0);
        chk("stat_stalls_off", stat_stalls_o, 0);
`endif
    endtask

    // Enter and leave at a negedge with the sequencer idle (unless stop_after >= 0,
    // which returns mid-burst after that many words have been taken).
    task automatic run_burst(input logic [31:0] eva, input int len, input logic [2:0] px,
                             input logic [3:0] py, input int pct, input int pre_stall,
                             input int stop_after);
        logic [31:0] cur;
        logic [6:0]  ex, ey;
        logic [27:0] eepa;
        int          pre;
        chk("cmd_ready_idle", cmd_ready_o, 1);
        cmd_v_i = 1'b1; cmd_eva_i = eva; cmd_len_i = 16'(len); pod_x_i = px; pod_y_i = py;
        @(negedge clk);
        cmd_v_i = 1'b0; cmd_eva_i = $urandom; cmd_len_i = 16'($urandom); pod_x_i = 3'($urandom); pod_y_i = 4'($urandom);
        if (len == 0) begin
            chk("len0_v", out_v_o, 0);
            chk("len0_done", done_o, 1);
            chk("len0_ready", cmd_ready_o, 0);
            @(negedge clk);
            chk("len0_done_off", done_o, 0);
            chk("len0_ready_back", cmd_ready_o, 1);
            chk_stats();
            return;
        end
        cur = {eva[31:2], 2'b00};
        pre = pre_stall;
        for (int k = 0; k < len; k++) begin
            bit taken;
            int waited;
            if (stop_after >= 0 && k == stop_after) return;
            hash_model(cur, px, py, ex, ey, eepa);
            taken  = 1'b0;
            waited = 0;
            while (!taken) begin
                bit y;
                chk("out_v", out_v_o, 1);
                chk("x_cord", out_x_cord_o, ex);
                chk("y_cord", out_y_cord_o, ey);
                chk("epa", out_epa_o, eepa);
                chk("line_first", out_line_first_o, (k == 0 || cur[4:2] == 3'd0));
                chk("last", out_last_o, (k == len - 1));
                chk("done_run", done_o, 0);
                chk("ready_run", cmd_ready_o, 0);
                if (k == 0 && pre > 0) begin
                    pre--;
                    y = 1'b0;
                end else begin
                    y = ($urandom_range(0, 99) < pct) || (waited >= 20);
                end
                out_yumi_i = y;
                if (y) m_words++; else m_stalls++;
                @(negedge clk);
                out_yumi_i = 1'b0;
                taken = y;
                waited++;
            end
            cur = cur + 32'd4;
        end
        chk("done_pulse", done_o, 1);
        chk("v_after_last", out_v_o, 0);
        chk("ready_in_done", cmd_ready_o, 0);
        @(negedge clk);
        chk("done_off", done_o, 0);
        chk("ready_back", cmd_ready_o, 1);
        chk_stats();
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        m_words = 0;
        m_stalls = 0;
    endtask

    initial begin
        reset_i = 1'b1; cmd_v_i = 1'b0; cmd_eva_i = '0; cmd_len_i = '0;
        pod_x_i = 3'd1; pod_y_i = 4'd2; out_yumi_i = 1'b0;
        m_words = 0; m_stalls = 0;
        @(negedge clk);
        do_reset();
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_v", out_v_o, 0);
        chk("rst_done", done_o, 0);
        chk_stats();

        run_burst(32'h0000_0000, 8, 3'd1, 4'd2, 100, 0, -1);
        run_burst(32'h0000_0200, 1, 3'd1, 4'd2, 100, 0, -1);
        run_burst(32'h0000_041C, 3, 3'd1, 4'd2, 100, 0, -1);
        run_burst(32'h0000_0040, 0, 3'd1, 4'd2, 100, 0, -1);
        run_burst(32'hFFFF_FFFC, 2, 3'd1, 4'd2, 50, 0, -1);
        run_burst(32'h0000_0123, 5, 3'd1, 4'd2, 50, 0, -1);

        // Reset in the middle of a burst: nothing left over, no done pulse.
        run_burst(32'h0000_1000, 10, 3'd1, 4'd2, 100, 0, 4);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        m_words = 0; m_stalls = 0;
        chk("midrst_v", out_v_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_ready", cmd_ready_o, 1);
        @(negedge clk);
        chk("midrst_done_late", done_o, 0);
        chk_stats();

        // Four words with three stall cycles in front of the first yumi.
        run_burst(32'h0000_0080, 4, 3'd1, 4'd2, 100, 3, -1);
`ifdef BSG_MANYCORE_DRAM_SEQ_STATS_EN
        chk("stats_words_4", stat_words_o, 4);
        chk("stats_stalls_3", stat_stalls_o, 3);
`endif

        // Max-length burst: last must not assert early, then abandon via reset.
        run_burst(32'h0000_3FE0, 16'hFFFF, 3'd5, 4'd9, 100, 0, 40);
        do_reset();
        chk("maxlen_rst_ready", cmd_ready_o, 1);

        for (int i = 0; i < 30; i++)
            run_burst($urandom, $urandom_range(0, 12), 3'($urandom), 4'($urandom),
                      $urandom_range(30, 100), 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    always @(negedge clk)
        if (!reset_i && out_yumi_i && !out_v_o) begin
            bad++;
            total++;
            $display("FAIL yumi_without_v got=1 exp=0");
        end

endmodule
